// File: rtl/tlk2711_pkg.sv
// Shared constants and types for the TLK2711 far-end frame generator.
// K-codes, header field widths and the frame generator state encoding.
package tlk2711_pkg;

  localparam logic [15:0] K_SOF  = 16'hFBFB;  // K27.7 K27.7
  localparam logic [15:0] K_EOF  = 16'hFDFD;  // K29.7 K29.7
  localparam logic [15:0] K_IDLE = 16'hBCC5;  // K28.5 D5.6

  localparam int HDR_NUM_W   = 16;
  localparam int HDR_LEN_W   = 16;
  localparam int FRAME_CNT_W = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SOF,
    ST_HDR_NUM,
    ST_HDR_LEN,
    ST_PAYLOAD,
    ST_CKSUM,
    ST_EOF,
    ST_IFG,
    ST_DONE
  } fgen_state_e;

endpackage

// File: rtl/tlk2711_prbs15.sv
// PRBS15 (x^15 + x^14 + 1) word generator, 16 bits per clock.
// o_word holds the next 16 bits, first generated bit in bit 15.
module tlk2711_prbs15 #(
  parameter logic [14:0] SEED = 15'h7FFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_adv,
  output logic [15:0] o_word
);

  logic [14:0] r_lfsr;
  logic [30:0] w_step;

  // Returns {state after 16 shifts, the 16 bits produced on the way}.
  function automatic logic [30:0] step16(input logic [14:0] s_in);
    logic [14:0] s;
    logic [15:0] w;
    logic        b;
    s = s_in;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      b = s[14] ^ s[13];
      s = {s[13:0], b};
      w = {w[14:0], b};
    end
    return {s, w};
  endfunction

  always_comb begin
    w_step = step16(r_lfsr);
  end

  assign o_word = w_step[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else if (i_load) begin
      r_lfsr <= SEED;
    end else if (i_adv) begin
      r_lfsr <= w_step[30:16];
    end
  end

endmodule

// File: rtl/tlk2711_frame_gen.sv
// Far-end TLK2711 frame transmitter: sync preamble then SOF/header/payload/cksum/EOF frames.
// Optional first-payload-word error injection is built only with TLK2711_FGEN_ERR_INJ_EN.
module tlk2711_frame_gen
  import tlk2711_pkg::*;
#(
  parameter int          SYNC_WORDS = 64,
  parameter logic [15:0] IDLE_WORD  = K_IDLE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic [FRAME_CNT_W-1:0] i_frame_num,
  input  logic [HDR_LEN_W-1:0]   i_payload_words,
  input  logic [7:0]             i_ifg_words,
  input  logic                   i_pattern_sel,
  input  logic                   i_err_inject,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt,
  output logic [15:0]            o_2711_txd,
  output logic                   o_2711_tkmsb,
  output logic                   o_2711_tklsb,
  output logic                   o_2711_enable,
  output logic                   o_2711_loopen,
  output logic                   o_2711_lckrefn,
  output fgen_state_e            o_dbg_state
);

  localparam logic [15:0] SYNC_LAST = 16'(SYNC_WORDS - 1);

  fgen_state_e            r_state, w_next;
  logic [15:0]            r_cnt;
  logic [FRAME_CNT_W-1:0] r_frame_num, r_frame_cnt;
  logic [HDR_LEN_W-1:0]   r_payload_words;
  logic [7:0]             r_ifg_words;
  logic                   r_pattern_sel, r_stop_pend;
  logic [15:0]            r_cksum;
  logic [15:0]            r_txd;
  logic                   r_tkmsb, r_tklsb, r_enable, r_lckrefn, r_busy, r_done;

  logic                   w_start, w_stop;
  logic [15:0]            w_prbs_word, w_pay_clean, w_pay_sent;
  logic [15:0]            w_txd;
  logic                   w_tkmsb, w_tklsb;

  assign w_start = (r_state == ST_IDLE) && i_start;
  assign w_stop  = r_stop_pend || i_stop;

  tlk2711_prbs15 #(.SEED(15'h7FFF)) u_prbs (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_start),
    .i_adv  ((r_state == ST_PAYLOAD) && r_pattern_sel),
    .o_word (w_prbs_word)
  );

  // The checksum always covers the clean word; only the line copy is corrupted.
  assign w_pay_clean = r_pattern_sel ? w_prbs_word : r_cnt;

`ifdef TLK2711_FGEN_ERR_INJ_EN
  logic r_err_armed;
  logic w_inj;

  assign w_inj      = r_err_armed && (r_state == ST_PAYLOAD) && (r_cnt == 16'd0);
  assign w_pay_sent = w_pay_clean ^ {15'd0, w_inj};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_armed <= 1'b0;
    end else if (w_inj) begin
      r_err_armed <= 1'b0;
    end else if (i_err_inject) begin
      r_err_armed <= 1'b1;
    end
  end
`else
  logic w_unused_err_inject;

  assign w_unused_err_inject = i_err_inject;
  assign w_pay_sent          = w_pay_clean;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (i_start) w_next = ST_SYNC;
      ST_SYNC: begin
        if (r_cnt == SYNC_LAST) begin
          w_next = ((r_frame_num == '0) || w_stop) ? ST_DONE : ST_SOF;
        end
      end
      ST_SOF:     w_next = ST_HDR_NUM;
      ST_HDR_NUM: w_next = ST_HDR_LEN;
      ST_HDR_LEN: w_next = (r_payload_words == '0) ? ST_CKSUM : ST_PAYLOAD;
      ST_PAYLOAD: if (r_cnt == r_payload_words - 16'd1) w_next = ST_CKSUM;
      ST_CKSUM:   w_next = ST_EOF;
      ST_EOF: begin
        if ((r_frame_cnt + 32'd1 == r_frame_num) || w_stop) w_next = ST_DONE;
        else if (r_ifg_words == 8'd0)                     w_next = ST_SOF;
        else                                              w_next = ST_IFG;
      end
      ST_IFG:     if (r_cnt == {8'd0, r_ifg_words} - 16'd1) w_next = ST_SOF;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_txd   = IDLE_WORD;
    w_tkmsb = 1'b1;
    w_tklsb = 1'b0;
    case (r_state)
      ST_SOF:     begin w_txd = K_SOF; w_tkmsb = 1'b1; w_tklsb = 1'b1; end
      ST_HDR_NUM: begin w_txd = r_frame_cnt[HDR_NUM_W-1:0]; w_tkmsb = 1'b0; end
      ST_HDR_LEN: begin w_txd = r_payload_words; w_tkmsb = 1'b0; end
      ST_PAYLOAD: begin w_txd = w_pay_sent; w_tkmsb = 1'b0; end
      ST_CKSUM:   begin w_txd = r_cksum; w_tkmsb = 1'b0; end
      ST_EOF:     begin w_txd = K_EOF; w_tkmsb = 1'b1; w_tklsb = 1'b1; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_frame_num     <= '0;
      r_frame_cnt     <= '0;
      r_payload_words <= '0;
      r_ifg_words     <= '0;
      r_pattern_sel   <= 1'b0;
      r_stop_pend     <= 1'b0;
      r_cksum         <= '0;
      r_txd           <= '0;
      r_tkmsb         <= 1'b0;
      r_tklsb         <= 1'b0;
      r_enable        <= 1'b0;
      r_lckrefn       <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
      r_txd     <= w_txd;
      r_tkmsb   <= w_tkmsb;
      r_tklsb   <= w_tklsb;
      r_enable  <= 1'b1;
      r_lckrefn <= 1'b1;
      r_done    <= (r_state == ST_DONE);

      if (w_start) begin
        r_frame_num     <= i_frame_num;
        r_payload_words <= i_payload_words;
        r_ifg_words     <= i_ifg_words;
        r_pattern_sel   <= i_pattern_sel;
        r_frame_cnt     <= '0;
        r_busy          <= 1'b1;
        r_stop_pend     <= i_stop;
      end else if ((r_state != ST_IDLE) && i_stop) begin
        r_stop_pend <= 1'b1;
      end

      if (r_state == ST_DONE) begin
        r_busy      <= 1'b0;
        r_stop_pend <= 1'b0;
      end

      if (r_state == ST_SOF)          r_cksum <= '0;
      else if (r_state == ST_PAYLOAD) r_cksum <= r_cksum + w_pay_clean;

      if (r_state == ST_EOF) r_frame_cnt <= r_frame_cnt + 32'd1;
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_frame_cnt    = r_frame_cnt;
  assign o_2711_txd     = r_txd;
  assign o_2711_tkmsb   = r_tkmsb;
  assign o_2711_tklsb   = r_tklsb;
  assign o_2711_enable  = r_enable;
  assign o_2711_loopen  = 1'b0;
  assign o_2711_lckrefn = r_lckrefn;
  assign o_dbg_state    = r_state;

endmodule
